// File: rtl/tp_pulse_stretch_pkg.sv
// tp_pkg: shared constants and helpers for the test-point pulse stretcher.
//   clog2 / sel_width : constant functions for deriving counter and select widths
//   *_DEF             : default parameter values for the top and channel modules
//   tp_chan_e         : which status strobe is wired to which channel index
package tp_pkg;

  localparam int NCH_DEF     = 8;
  localparam int STRETCH_DEF = 16;
  localparam int CW_DEF      = 16;
  localparam int HB_DIV_DEF  = 20;

  typedef enum logic [3:0] {
    CH_L1A          = 4'd0,
    CH_L1A_MATCH    = 4'd1,
    CH_L1A_PUSH_SKW = 4'd2,
    CH_L1A_PUSH_MAC = 4'd3,
    CH_RESYNC       = 4'd4,
    CH_ALG_GD       = 4'd5,
    CH_SYS_RST      = 4'd6,
    CH_SPARE        = 4'd7
  } tp_chan_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >>> 1;
    end
    return r;
  endfunction

  // A one-channel build still needs a one-bit select port.
  function automatic int sel_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tp_pulse_stretch_if.sv
// tp_pulse_stretch_if: bundles the event, control and status signals of the stretcher.
//   EVT_IN    event strobes (one per channel)
//   RETRIG    1: a new rise reloads an active stretch
//   CNT_CLR   synchronous clear of counters and overflow flags
//   CNT_SEL   channel shown on CNT_OUT
//   TP_STR    stretched pulses
//   CNT_OUT   registered count of the selected channel
//   OVF       sticky saturation flags
//   HEARTBEAT slow liveness toggle
// master drives the inputs of the block, slave is the block itself.
interface tp_pulse_stretch_if
  import tp_pkg::*;
#(
  parameter int NCH  = NCH_DEF,
  parameter int CW   = CW_DEF,
  parameter int SELW = sel_width(NCH)
);
  logic [NCH-1:0]  EVT_IN;
  logic            RETRIG;
  logic            CNT_CLR;
  logic [SELW-1:0] CNT_SEL;
  logic [NCH-1:0]  TP_STR;
  logic [CW-1:0]   CNT_OUT;
  logic [NCH-1:0]  OVF;
  logic            HEARTBEAT;

  modport master (
    output EVT_IN, RETRIG, CNT_CLR, CNT_SEL,
    input  TP_STR, CNT_OUT, OVF, HEARTBEAT
  );

  modport slave (
    input  EVT_IN, RETRIG, CNT_CLR, CNT_SEL,
    output TP_STR, CNT_OUT, OVF, HEARTBEAT
  );
endinterface

// File: rtl/tp_pulse_stretch_chan.sv
// tp_stretch_chan: one event channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   evt_in     : event strobe, any width; each rising edge is one event
//   retrig     : 1 lets a rise during an active stretch reload it
//   cnt_clr    : clears the counter and overflow flag (stretcher untouched)
//   str_out    : stretched pulse, STRETCH cycles per accepted rise
//   cnt        : saturating event count
//   ovf        : sticky flag, set by a rise while the count is saturated
module tp_stretch_chan
  import tp_pkg::*;
#(
  parameter int STRETCH = STRETCH_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          evt_in,
  input  logic          retrig,
  input  logic          cnt_clr,
  output logic          str_out,
  output logic [CW-1:0] cnt,
  output logic          ovf
);
  localparam int            SW    = clog2(STRETCH + 1);
  localparam logic [SW-1:0] SLOAD = SW'(STRETCH);
  localparam logic [CW-1:0] CMAX  = '1;

  logic          evt_s1_q, evt_s1_d;
  logic          evt_s2_q, evt_s2_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          rise;

  always_comb begin
    evt_s1_d = evt_in;
    evt_s2_d = evt_s1_q;
    rise     = evt_s1_q & ~evt_s2_q;

    scnt_d = scnt_q;
    if (rise && (retrig || scnt_q == '0)) begin
      scnt_d = SLOAD;
    end else if (scnt_q != '0) begin
      scnt_d = scnt_q - 1'b1;
    end

    // Clear has priority over a coincident rise; the rise is lost.
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (cnt_clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (rise) begin
      if (cnt_q == CMAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_s1_q <= 1'b0;
      evt_s2_q <= 1'b0;
      scnt_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      evt_s1_q <= evt_s1_d;
      evt_s2_q <= evt_s2_d;
      scnt_q   <= scnt_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign str_out = (scnt_q != '0);
  assign cnt     = cnt_q;
  assign ovf     = ovf_q;
endmodule

// File: rtl/tp_pulse_stretch.sv
// tp_pulse_stretch: conditions single-cycle status strobes for test-point output.
//   CLK   : system clock, rising edge
//   RST_B : asynchronous active-low reset
//   bus   : slave side of tp_pulse_stretch_if (EVT_IN, RETRIG, CNT_CLR, CNT_SEL in;
//           TP_STR, CNT_OUT, OVF, HEARTBEAT out)
// One tp_stretch_chan per channel, plus the count readout mux and a heartbeat
// toggling every 2^HB_DIV cycles.
module tp_pulse_stretch
  import tp_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int STRETCH = STRETCH_DEF,
  parameter int CW      = CW_DEF,
  parameter int HB_DIV  = HB_DIV_DEF
) (
  input  logic              CLK,
  input  logic              RST_B,
  tp_pulse_stretch_if.slave bus
);
  logic [NCH-1:0] str_vec;
  logic [NCH-1:0] ovf_vec;
  logic [CW-1:0]  cnt_arr [NCH];

  logic [CW-1:0]     cnt_out_q, cnt_out_d;
  logic [HB_DIV-1:0] hb_cnt_q, hb_cnt_d;
  logic              hb_q, hb_d;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      tp_stretch_chan #(
        .STRETCH (STRETCH),
        .CW      (CW)
      ) u_chan (
        .clk     (CLK),
        .rst_n   (RST_B),
        .evt_in  (bus.EVT_IN[gi]),
        .retrig  (bus.RETRIG),
        .cnt_clr (bus.CNT_CLR),
        .str_out (str_vec[gi]),
        .cnt     (cnt_arr[gi]),
        .ovf     (ovf_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    // Select codes past the last channel read as zero.
    cnt_out_d = '0;
    if (int'(bus.CNT_SEL) < NCH) begin
      cnt_out_d = cnt_arr[bus.CNT_SEL];
    end
    hb_cnt_d = hb_cnt_q + 1'b1;
    hb_d     = hb_q ^ (&hb_cnt_q);
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      cnt_out_q <= '0;
      hb_cnt_q  <= '0;
      hb_q      <= 1'b0;
    end else begin
      cnt_out_q <= cnt_out_d;
      hb_cnt_q  <= hb_cnt_d;
      hb_q      <= hb_d;
    end
  end

  assign bus.TP_STR    = str_vec;
  assign bus.OVF       = ovf_vec;
  assign bus.CNT_OUT   = cnt_out_q;
  assign bus.HEARTBEAT = hb_q;
endmodule

// File: tb/tb_tp_pulse_stretch.sv
module tb_tp_pulse_stretch;
  import tp_pkg::*;

  localparam int NCH     = 6;
  localparam int STRETCH = 16;
  localparam int CW      = 4;
  localparam int HB_DIV  = 4;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  tp_pulse_stretch_if #(.NCH(NCH), .CW(CW)) bus ();

  tp_pulse_stretch #(
    .NCH     (NCH),
    .STRETCH (STRETCH),
    .CW      (CW),
    .HB_DIV  (HB_DIV)
  ) dut (
    .CLK   (clk),
    .RST_B (rst_b),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  typedef struct {
    int ch;
    int width;
    int gap;      // start of a second pulse, 0 = none
    bit retrig;
    int exp_lat;
    int exp_len;
    int exp_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: got %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int first;
    int len;
    int stray;
    logic [NCH-1:0] others;
    first = -1;
    len = 0;
    stray = 0;
    bus.CNT_CLR = 1'b1;
    tick();
    bus.CNT_CLR = 1'b0;
    bus.RETRIG = v.retrig;
    tick();
    exp_q.push_back(v.exp_lat);
    exp_q.push_back(v.exp_len);
    exp_q.push_back(v.exp_cnt);
    for (int c = 0; c < 60; c++) begin
      bus.EVT_IN = '0;
      if (c < v.width || (v.gap > 0 && c >= v.gap && c < v.gap + v.width))
        bus.EVT_IN[v.ch] = 1'b1;
      @(negedge clk);
      if (bus.TP_STR[v.ch]) begin
        if (first < 0) first = c;
        len++;
      end
      others = bus.TP_STR;
      others[v.ch] = 1'b0;
      if (others != '0) stray++;
      tick();
    end
    bus.EVT_IN = '0;
    bus.CNT_SEL = 3'(v.ch);
    tick();
    tick();
    @(negedge clk);
    check($sformatf("vec%0d latency", idx), first, exp_q.pop_front());
    check($sformatf("vec%0d length", idx), len, exp_q.pop_front());
    check($sformatf("vec%0d count", idx), int'(bus.CNT_OUT), exp_q.pop_front());
    check($sformatf("vec%0d stray", idx), stray, 0);
  endtask

  task automatic pulse(input int ch, input int low_after);
    bus.EVT_IN[ch] = 1'b1;
    tick();
    bus.EVT_IN[ch] = 1'b0;
    repeat (low_after) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lim;
    int len;
    int t0;
    int iv[2];
    logic hb_prev;

    //            ch                 w  gap r  lat len cnt
    vecs[0] = '{int'(CH_L1A),        1, 0,  0, 2, 16, 1};
    vecs[1] = '{int'(CH_L1A_MATCH),  1, 10, 1, 2, 26, 2};
    vecs[2] = '{int'(CH_L1A_MATCH),  1, 10, 0, 2, 16, 2};
    vecs[3] = '{int'(CH_RESYNC),     5, 0,  1, 2, 16, 1};
    vecs[4] = '{int'(CH_ALG_GD),     1, 2,  1, 2, 18, 2};
    vecs[5] = '{3,                   1, 16, 0, 2, 16, 2};
    vecs[6] = '{0,                   1, 16, 1, 2, 32, 2};

    bus.EVT_IN  = '0;
    bus.RETRIG  = 1'b0;
    bus.CNT_CLR = 1'b0;
    bus.CNT_SEL = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst tp_str", int'(bus.TP_STR), 0);
    check("rst cnt_out", int'(bus.CNT_OUT), 0);
    check("rst ovf", int'(bus.OVF), 0);
    check("rst heartbeat", int'(bus.HEARTBEAT), 0);
    rst_b = 1'b1;
    repeat (100) tick();
    @(negedge clk);
    check("idle tp_str", int'(bus.TP_STR), 0);
    check("idle cnt_out", int'(bus.CNT_OUT), 0);
    check("idle ovf", int'(bus.OVF), 0);
    tick();

    // Table-driven stretch / retrigger / count vectors
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Select beyond last channel reads zero (ch0 currently holds 2)
    bus.CNT_SEL = 3'd6;
    tick(); tick();
    @(negedge clk);
    check("sel6 cnt_out", int'(bus.CNT_OUT), 0);
    bus.CNT_SEL = 3'd7;
    tick(); tick();
    @(negedge clk);
    check("sel7 cnt_out", int'(bus.CNT_OUT), 0);
    bus.CNT_SEL = 3'd0;
    tick(); tick();
    @(negedge clk);
    check("sel0 cnt_out", int'(bus.CNT_OUT), 2);
    tick();

    // Saturation and overflow on ch2
    bus.CNT_CLR = 1'b1;
    tick();
    bus.CNT_CLR = 1'b0;
    bus.RETRIG = 1'b0;
    bus.CNT_SEL = 3'd2;
    for (int p = 0; p < 15; p++) pulse(2, 2);
    repeat (3) tick();
    @(negedge clk);
    check("sat15 count", int'(bus.CNT_OUT), 15);
    check("sat15 ovf2", int'(bus.OVF[2]), 0);
    tick();
    pulse(2, 4);
    @(negedge clk);
    check("sat16 count", int'(bus.CNT_OUT), 15);
    check("sat16 ovf2", int'(bus.OVF[2]), 1);
    tick();
    repeat (20) tick();
    // Clear in the same cycle as the rise: clear wins, stretch still happens
    bus.EVT_IN[2] = 1'b1;
    tick();
    bus.EVT_IN[2] = 1'b0;
    bus.CNT_CLR = 1'b1;
    tick();
    bus.CNT_CLR = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("clr+rise count", int'(bus.CNT_OUT), 0);
    check("clr+rise ovf", int'(bus.OVF), 0);
    check("clr+rise tp_str2", int'(bus.TP_STR[2]), 1);
    tick();
    repeat (20) tick();

    // Asynchronous reset in the middle of a stretch
    bus.EVT_IN[0] = 1'b1;
    tick();
    bus.EVT_IN[0] = 1'b0;
    len = 0;
    lim = 0;
    while (len < 5 && lim < 40) begin
      @(negedge clk);
      if (bus.TP_STR[0]) len++;
      lim++;
    end
    check("pre-rst stretch seen", len, 5);
    #2;
    rst_b = 1'b0;
    bus.EVT_IN[3] = 1'b1;
    #1;
    check("async rst tp_str", int'(bus.TP_STR), 0);
    check("async rst cnt_out", int'(bus.CNT_OUT), 0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    // Level held across release: exactly one event
    len = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.TP_STR[3]) len++;
    end
    check("held-level length", len, 16);
    tick();
    bus.EVT_IN = '0;
    bus.CNT_SEL = 3'd3;
    tick(); tick();
    @(negedge clk);
    check("held-level count", int'(bus.CNT_OUT), 1);

    // Heartbeat: toggles every 2^HB_DIV cycles
    hb_prev = bus.HEARTBEAT;
    lim = 0;
    while (bus.HEARTBEAT == hb_prev && lim < 100) begin
      @(negedge clk);
      lim++;
    end
    for (int k = 0; k < 2; k++) begin
      hb_prev = bus.HEARTBEAT;
      t0 = 0;
      while (t0 < 100) begin
        @(negedge clk);
        t0++;
        if (bus.HEARTBEAT != hb_prev) break;
      end
      iv[k] = (t0 < 100) ? t0 : -1;
    end
    check("hb half-period 1", iv[0], 16);
    check("hb half-period 2", iv[1], 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
